// File: rtl/mcycle_unit_if.sv
// Request/response bundle between the Execute stage and the iterative
// multiply/divide engine.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic             Signed;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Signed, Operand1, Operand2,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Signed, Operand1, Operand2,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative multi-cycle multiply/divide engine. One shift-add (MUL) or
// restoring-division (DIV) iteration per clock, WIDTH iterations per op.
// Signed operations run on magnitudes; signs are fixed up on the last step.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  mcycle_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} stateT;

  stateT state, nextState;

  logic             accept;     // Start sampled outside COMPUTE
  logic             lastIter;   // final iteration edge
  logic [CW-1:0]    count;

  // Captured operation context
  logic             isDiv;
  logic             negLo;      // MUL: negate product; DIV: negate quotient
  logic             negHi;      // DIV: negate remainder
  logic             divByZero;
  logic [WIDTH-1:0] rawA;       // dividend as presented, for divide-by-zero
  logic [WIDTH-1:0] operand;    // MUL: multiplicand magnitude; DIV: divisor magnitude

  // Shared accumulator. MUL: {product high, multiplier/product low}.
  // DIV: {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0] accHi, accLo;

  // Operand magnitudes and sign flags at capture time
  logic             signA, signB;
  logic [WIDTH-1:0] magA, magB;

  // Iteration datapath
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHi, mulLo;
  logic [WIDTH:0]   divShift, divTrial;
  logic             divFits;
  logic [WIDTH-1:0] divHi, divLo;
  logic [WIDTH-1:0] stepHi, stepLo;

  // Sign-corrected final results
  logic [2*WIDTH-1:0] prodRaw, prodFix;
  logic [WIDTH-1:0]   quoFix, remFix;
  logic [WIDTH-1:0]   finR1, finR2;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.Start) nextState = COMPUTE;
      COMPUTE: if (count == LAST) nextState = DONE;
      DONE:    nextState = bus.Start ? COMPUTE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs; Busy is combinational on Start so the stall starts at once
  always_comb begin
    accept   = bus.Start && (state != COMPUTE);
    lastIter = (state == COMPUTE) && (count == LAST);
    bus.Busy = accept || (state == COMPUTE);
    bus.Done = (state == DONE);
  end

  // Operand magnitudes for the signed path
  always_comb begin
    signA = bus.Signed && bus.Operand1[WIDTH-1];
    signB = bus.Signed && bus.Operand2[WIDTH-1];
    magA  = signA ? -bus.Operand1 : bus.Operand1;
    magB  = signB ? -bus.Operand2 : bus.Operand2;
  end

  // One MUL iteration and one DIV iteration, selected by the captured op
  always_comb begin
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    mulHi    = mulSum[WIDTH:1];
    mulLo    = {mulSum[0], accLo[WIDTH-1:1]};

    divShift = {accHi, accLo[WIDTH-1]};
    divTrial = divShift - {1'b0, operand};
    divFits  = !divTrial[WIDTH];
    divHi    = divFits ? divTrial[WIDTH-1:0] : divShift[WIDTH-1:0];
    divLo    = {accLo[WIDTH-2:0], divFits};

    stepHi   = isDiv ? divHi : mulHi;
    stepLo   = isDiv ? divLo : mulLo;
  end

  // Sign fix-up and boundary handling applied to the last iteration result
  always_comb begin
    prodRaw = {stepHi, stepLo};
    prodFix = negLo ? -prodRaw : prodRaw;
    quoFix  = negLo ? -stepLo : stepLo;
    remFix  = negHi ? -stepHi : stepHi;
    if (isDiv) begin
      finR1 = divByZero ? '1   : quoFix;
      finR2 = divByZero ? rawA : remFix;
    end else begin
      finR1 = prodFix[WIDTH-1:0];
      finR2 = prodFix[2*WIDTH-1:WIDTH];
    end
  end

  // Capture on accept, iterate in COMPUTE, latch results on the last edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count       <= '0;
      isDiv       <= 1'b0;
      negLo       <= 1'b0;
      negHi       <= 1'b0;
      divByZero   <= 1'b0;
      rawA        <= '0;
      operand     <= '0;
      accHi       <= '0;
      accLo       <= '0;
      bus.Result1 <= '0;
      bus.Result2 <= '0;
    end else if (accept) begin
      count     <= '0;
      isDiv     <= bus.MCycleOp;
      negLo     <= signA ^ signB;
      negHi     <= signA;
      divByZero <= (bus.Operand2 == '0);
      rawA      <= bus.Operand1;
      accHi     <= '0;
      if (bus.MCycleOp) begin
        operand <= magB;
        accLo   <= magA;
      end else begin
        operand <= magA;
        accLo   <= magB;
      end
    end else if (state == COMPUTE) begin
      count <= count + 1'b1;
      accHi <= stepHi;
      accLo <= stepLo;
      if (lastIter) begin
        bus.Result1 <= finR1;
        bus.Result2 <= finR2;
      end
    end
  end
endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit: stimulus pushes expected results and
// the completion cycle; a monitor pops and checks on every Done.
module tb_mcycle_unit;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic CLK = 1'b0;
  logic RESET;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    int          doneCyc;
  } expT;

  expT sb[$];

  mcycle_unit_if #(.WIDTH(W)) bus();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding request
  always @(negedge CLK) begin
    if (!RESET && bus.Done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'd1, 64'd0);
      end else begin
        expT e;
        e = sb.pop_front();
        chk({e.name, "_r1"}, {32'd0, bus.Result1}, {32'd0, e.r1});
        chk({e.name, "_r2"}, {32'd0, bus.Result2}, {32'd0, e.r2});
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.doneCyc));
      end
    end
  end

  // Reference model: plain 64-bit arithmetic on the specified rules
  task automatic model(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r1, output logic [31:0] r2);
    longint sa, sbv;
    logic [63:0] p, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (!op) begin
      if (sgn) p = 64'(sa * sbv);
      else     p = {32'd0, a} * {32'd0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == 32'd0) begin
      r1 = 32'hFFFF_FFFF;
      r2 = a;
    end else begin
      if (sgn) begin
        q = 64'(sa / sbv);
        r = 64'(sa % sbv);
      end else begin
        q = {32'd0, a / b};
        r = {32'd0, a % b};
      end
      r1 = q[31:0];
      r2 = r[31:0];
    end
  endtask

  task automatic drive(input bit op, input bit sgn, input logic [31:0] a, input logic [31:0] b);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Signed   = sgn;
    bus.Operand1 = a;
    bus.Operand2 = b;
  endtask

  // Drop Start and scramble operands to show they were captured
  task automatic releaseStart();
    bus.Start    = 1'b0;
    bus.MCycleOp = 1'($urandom);
    bus.Signed   = 1'($urandom);
    bus.Operand1 = $urandom;
    bus.Operand2 = $urandom;
  endtask

  // Called at a negedge: issue a request and enqueue its expectation
  task automatic issueExp(input string name, input bit op, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r1, input logic [31:0] r2);
    expT e;
    drive(op, sgn, a, b);
    #1;
    chk({name, "_busy_c0"}, {63'd0, bus.Busy}, 64'd1);
    e.name = name; e.r1 = r1; e.r2 = r2; e.doneCyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic issueModel(input string name, input bit op, input bit sgn,
                            input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r1, r2;
    model(op, sgn, a, b, r1, r2);
    issueExp(name, op, sgn, a, b, r1, r2);
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) begin
      @(posedge CLK); #2;
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic single(input string name, input bit op, input bit sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r1, input logic [31:0] r2);
    @(negedge CLK);
    issueExp(name, op, sgn, a, b, r1, r2);
    @(negedge CLK);
    releaseStart();
    waitDrain();
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(7))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'(($urandom_range(15)));
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] a, b;
    bit op, sgn;
    RESET = 1'b1;
    bus.Start = 1'b0; bus.MCycleOp = 1'b0; bus.Signed = 1'b0;
    bus.Operand1 = '0; bus.Operand2 = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {63'd0, bus.Busy}, 64'd0);
    chk("rst_done", {63'd0, bus.Done}, 64'd0);
    chk("rst_r1", {32'd0, bus.Result1}, 64'd0);
    chk("rst_r2", {32'd0, bus.Result2}, 64'd0);
    RESET = 1'b0;

    // Unsigned 7*6 with Busy profile across the whole operation
    @(negedge CLK);
    issueExp("mul_u_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 32'd42, 32'd0);
    for (int i = 1; i <= W; i++) begin
      @(negedge CLK);
      if (i == 1) releaseStart();
      #1;
      chk($sformatf("busy_c%0d", i), {63'd0, bus.Busy}, 64'd1);
    end
    @(negedge CLK); #1;
    chk("busy_done_cycle", {63'd0, bus.Busy}, 64'd0);
    chk("done_at_33", {63'd0, bus.Done}, 64'd1);
    waitDrain();

    // Directed corner cases
    single("mul_s_m3x5",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
    single("div_u_100_7",  1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    single("div_s_m100_7", 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    single("div_u_by0",    1'b1, 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234);
    single("div_s_by0",    1'b1, 1'b1, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF00);
    single("div_s_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    single("mul_s_by0",    1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    single("mul_s_minmin", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'h4000_0000);
    single("mul_u_maxmax", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE);

    // Start during COMPUTE is ignored
    @(negedge CLK);
    issueExp("ignore_mid", 1'b0, 1'b0, 32'd1000, 32'd3, 32'd3000, 32'd0);
    @(negedge CLK); releaseStart();
    repeat (9) @(negedge CLK);
    drive(1'b1, 1'b1, 32'h5555_5555, 32'd9);
    @(negedge CLK); releaseStart();
    waitDrain();

    // Back-to-back: new Start in the DONE cycle
    @(negedge CLK);
    issueExp("b2b_first", 1'b1, 1'b0, 32'd50, 32'd8, 32'd6, 32'd2);
    @(negedge CLK); releaseStart();
    repeat (W) @(negedge CLK);
    #1;
    chk("b2b_done_first", {63'd0, bus.Done}, 64'd1);
    issueExp("b2b_second", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd4, 32'd0);
    @(negedge CLK); releaseStart();
    #1;
    chk("b2b_hold_r1", {32'd0, bus.Result1}, 64'd6);
    waitDrain();

    // Reset mid-operation aborts without Done and clears results
    @(negedge CLK);
    issueExp("aborted", 1'b0, 1'b0, 32'd123, 32'd456, 32'd0, 32'd0);
    @(negedge CLK); releaseStart();
    repeat (14) @(negedge CLK);
    RESET = 1'b1;
    void'(sb.pop_back());
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
    chk("abort_done", {63'd0, bus.Done}, 64'd0);
    chk("abort_r1", {32'd0, bus.Result1}, 64'd0);
    chk("abort_r2", {32'd0, bus.Result2}, 64'd0);
    repeat (40) @(negedge CLK);
    single("after_abort", 1'b1, 1'b1, 32'd77, 32'hFFFF_FFF9, 32'hFFFF_FFF5, 32'd0);

    // Randomized traffic, sometimes chained back-to-back
    @(negedge CLK);
    for (int n = 0; n < 30; n++) begin
      op  = 1'($urandom);
      sgn = 1'($urandom);
      a   = pickOperand();
      b   = pickOperand();
      issueModel($sformatf("rnd%0d", n), op, sgn, a, b);
      @(negedge CLK); releaseStart();
      repeat (W - 1) @(negedge CLK);
      if ($urandom_range(2) == 0) begin
        @(negedge CLK);
      end else begin
        waitDrain();
        @(negedge CLK);
      end
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
